// File: rtl/xm_wb_ram_responder.sv
// xm_wb_ram_responder
//   Wishbone classic-cycle slave that fronts a word-organised RAM with
//   byte-lane write enables. Each accepted request waits WAIT cycles and then
//   ends with a one-cycle ack_o. A request whose address lies beyond the RAM
//   ends with err_o instead. All outputs are registered.
//
// Parameters
//   WORD        data width in bits (byte lanes = WORD/8)
//   ADR_W       word-address width
//   DEPTH_LOG2  log2 of RAM depth in words (<= ADR_W)
//   WAIT        wait states before termination, 0..15
//
// Ports
//   clk_i   rising-edge clock
//   rst_ni  synchronous active-low reset
//   cyc_i   bus cycle in progress
//   stb_i   transfer strobe
//   we_i    1 = write, 0 = read
//   sel_i   byte-lane enables, bit n covers dat_i[8n+7:8n]
//   adr_i   word address
//   dat_i   write data
//   ack_o   normal termination pulse
//   err_o   error termination pulse (address out of range)
//   dat_o   read data, non-zero only while ack_o is high on a read
module xm_wb_ram_responder #(
  parameter int WORD       = 16,
  parameter int ADR_W      = WORD - (WORD / 8) + 1,
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT       = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [WORD/8-1:0]   sel_i,
  input  logic [ADR_W-1:0]    adr_i,
  input  logic [WORD-1:0]     dat_i,
  output logic                ack_o,
  output logic                err_o,
  output logic [WORD-1:0]     dat_o
);

  localparam int         LANES    = WORD / 8;
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_TERM
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic              we_q, we_d;
  logic [LANES-1:0]  sel_q, sel_d;
  logic [WORD-1:0]   wdat_q, wdat_d;
  logic              bad_q, bad_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [WORD-1:0]   rdat_q, rdat_d;

  logic [WORD-1:0]   mem [DEPTH];

  // The request acted on when entering TERM. With WAIT=0 the transfer
  // terminates on the same edge it is accepted, so the live inputs must be
  // used in IDLE; otherwise the latched copy is used.
  logic              req_we;
  logic [LANES-1:0]  req_sel;
  logic [ADR_W-1:0]  req_adr;
  logic [WORD-1:0]   req_dat;
  logic              req_bad;
  logic              adr_bad;
  logic              enter_term;
  logic              ram_wr;
  logic [DEPTH_LOG2-1:0] ram_idx;

  // Any address bit at or above DEPTH_LOG2 means the word is not backed by RAM.
  assign adr_bad = (adr_i >> DEPTH_LOG2) != '0;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    adr_d      = adr_q;
    we_d       = we_q;
    sel_d      = sel_q;
    wdat_d     = wdat_q;
    bad_d      = bad_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    rdat_d     = '0;
    enter_term = 1'b0;
    req_we     = we_q;
    req_sel    = sel_q;
    req_adr    = adr_q;
    req_dat    = wdat_q;
    req_bad    = bad_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          adr_d   = adr_i;
          we_d    = we_i;
          sel_d   = sel_i;
          wdat_d  = dat_i;
          bad_d   = adr_bad;
          cnt_d   = WAIT_CNT;
          req_we  = we_i;
          req_sel = sel_i;
          req_adr = adr_i;
          req_dat = dat_i;
          req_bad = adr_bad;
          if (WAIT_CNT == 4'd0) begin
            state_d    = ST_TERM;
            enter_term = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        // Master abandoning the cycle wins over a pending termination.
        if (!cyc_i) begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d    = ST_TERM;
          enter_term = 1'b1;
          cnt_d      = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_TERM: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ram_idx = req_adr[DEPTH_LOG2-1:0];
    ram_wr  = enter_term && req_we && !req_bad;

    if (enter_term) begin
      ack_d = !req_bad;
      err_d = req_bad;
      if (!req_bad && !req_we) begin
        rdat_d = mem[ram_idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
      bad_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
      bad_q   <= bad_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  // RAM contents survive reset; reset only suppresses a write in flight.
  always_ff @(posedge clk_i) begin
    if (rst_ni && ram_wr) begin
      for (int n = 0; n < LANES; n++) begin
        if (req_sel[n]) begin
          mem[ram_idx][8*n +: 8] <= req_dat[8*n +: 8];
        end
      end
    end
  end

  assign ack_o = ack_q;
  assign err_o = err_q;
  assign dat_o = rdat_q;

endmodule

// File: tb/tb_xm_wb_ram_responder.sv
module tb_xm_wb_ram_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  cyc, stb, we;
  logic [1:0]  sel  [3];
  logic [14:0] adr  [3];
  logic [15:0] dat  [3];
  logic [2:0]  ack, err;
  logic [15:0] dato [3];

  int n_chk = 0;
  int n_err = 0;
  int waits [3] = '{1, 3, 0};

  // Reference memory per instance, with per-byte "has been written" flags.
  logic [15:0] mdl [3][1024];
  logic [1:0]  kn  [3][1024];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    xm_wb_ram_responder #(
      .WORD(16), .ADR_W(15), .DEPTH_LOG2(10),
      .WAIT(g == 0 ? 1 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .cyc_i (cyc[g]),
      .stb_i (stb[g]),
      .we_i  (we[g]),
      .sel_i (sel[g]),
      .adr_i (adr[g]),
      .dat_i (dat[g]),
      .ack_o (ack[g]),
      .err_o (err[g]),
      .dat_o (dato[g])
    );
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One bus transfer on instance k. Holds cyc/stb until a termination is seen
  // (bounded), scrambling the request inputs while waiting, then checks the
  // following cycle is quiet.
  task automatic xfer(input int k, input logic w, input logic [1:0] s,
                      input logic [14:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic ak, output logic er,
                      output int lat);
    @(negedge clk);
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; sel[k] = s; adr[k] = a; dat[k] = d;
    rd = '0; ak = 1'b0; er = 1'b0; lat = 0;
    @(posedge clk);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (ack[k] || err[k]) begin
        ak = ack[k]; er = err[k]; rd = dato[k]; lat = i;
        break;
      end
      adr[k] = 15'($urandom); dat[k] = 16'($urandom);
      sel[k] = 2'($urandom);  we[k]  = 1'($urandom);
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
    @(negedge clk);
    chk_eq("post_ack", ack[k], 0);
    chk_eq("post_err", err[k], 0);
    chk_eq("post_dat", dato[k], 0);
  endtask

  // Transfer plus comparison against the reference memory.
  task automatic op(input int k, input logic w, input logic [1:0] s,
                    input logic [14:0] a, input logic [15:0] d,
                    output logic [15:0] rd);
    logic ak, er, bad;
    int   lat;
    logic [15:0] mask;
    bad = (a >= 15'd1024);
    xfer(k, w, s, a, d, rd, ak, er, lat);
    chk_eq("latency", lat, waits[k] + 1);
    chk_eq("ack", ak, !bad);
    chk_eq("err", er, bad);
    if (bad) begin
      chk_eq("err_dat", rd, 0);
    end else if (!w) begin
      mask = {{8{kn[k][a[9:0]][1]}}, {8{kn[k][a[9:0]][0]}}};
      chk_eq("rd_dat", rd & mask, mdl[k][a[9:0]] & mask);
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (s[n]) begin
          mdl[k][a[9:0]][8*n +: 8] = d[8*n +: 8];
          kn[k][a[9:0]][n] = 1'b1;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rd;
    logic        ak, er;
    int          lat, nack, last;
    logic        w;
    logic [1:0]  s;
    logic [14:0] a;

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1024; i++) kn[k][i] = 2'b00;
      sel[k] = '0; adr[k] = '0; dat[k] = '0;
    end
    cyc = '0; stb = '0; we = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk_eq("rst_ack", ack[k], 0);
      chk_eq("rst_err", err[k], 0);
      chk_eq("rst_dat", dato[k], 0);
    end
    rst_n = 1'b1;

    // Basic write/read, WAIT=1
    op(0, 1'b1, 2'b11, 15'h0005, 16'hBEEF, rd);
    op(0, 1'b0, 2'b11, 15'h0005, 16'h0000, rd);
    chk_eq("beef", rd, 16'hBEEF);

    // Byte lanes
    op(0, 1'b1, 2'b11, 15'h0020, 16'h1234, rd);
    op(0, 1'b1, 2'b10, 15'h0020, 16'hAB00, rd);
    op(0, 1'b1, 2'b01, 15'h0020, 16'h00CD, rd);
    op(0, 1'b0, 2'b00, 15'h0020, 16'h0000, rd);
    chk_eq("lanes", rd, 16'hABCD);
    op(0, 1'b1, 2'b00, 15'h0020, 16'hFFFF, rd);
    op(0, 1'b0, 2'b11, 15'h0020, 16'h0000, rd);
    chk_eq("sel00", rd, 16'hABCD);

    // Out of range
    op(0, 1'b1, 2'b11, 15'h03FF, 16'h4242, rd);
    op(0, 1'b0, 2'b11, 15'h0400, 16'h0000, rd);
    op(0, 1'b1, 2'b11, 15'h7FFF, 16'h9999, rd);
    op(0, 1'b0, 2'b11, 15'h03FF, 16'h0000, rd);
    chk_eq("edge_word", rd, 16'h4242);

    // Abort, WAIT=3
    op(1, 1'b1, 2'b11, 15'h0010, 16'h1111, rd);
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 2'b11;
    adr[1] = 15'h0010; dat[1] = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_eq("abort_ack", ack[1], 0);
      chk_eq("abort_err", err[1], 0);
    end
    op(1, 1'b0, 2'b11, 15'h0010, 16'h0000, rd);
    chk_eq("abort_nowr", rd, 16'h1111);

    // Reset during WAIT of a write
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 2'b11;
    adr[1] = 15'h0010; dat[1] = 16'h7777;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_eq("rstmid_ack", ack[1], 0);
    chk_eq("rstmid_err", err[1], 0);
    chk_eq("rstmid_dat", dato[1], 0);
    rst_n = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
    op(1, 1'b0, 2'b11, 15'h0010, 16'h0000, rd);
    chk_eq("rstmid_nowr", rd, 16'h1111);
    op(1, 1'b1, 2'b11, 15'h0010, 16'h2222, rd);
    op(1, 1'b0, 2'b11, 15'h0010, 16'h0000, rd);
    chk_eq("rstmid_after", rd, 16'h2222);

    // WAIT=0 back-to-back reads with stb held high
    for (int i = 1; i <= 3; i++) op(2, 1'b1, 2'b11, 15'(i), 16'($urandom), rd);
    @(negedge clk);
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b0; sel[2] = 2'b11; adr[2] = 15'd1;
    nack = 0; last = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack[2]) begin
        chk_eq("b2b_dat", dato[2], mdl[2][nack + 1]);
        if (nack == 0) chk_eq("b2b_first", i, 1);
        else           chk_eq("b2b_gap", i - last, 2);
        last = i;
        nack++;
        if (nack == 3) begin cyc[2] = 1'b0; stb[2] = 1'b0; end
        else adr[2] = 15'(nack + 1);
      end
    end
    chk_eq("b2b_count", nack, 3);

    // Randomized traffic on every instance
    for (int k = 0; k < 3; k++) begin
      for (int t = 0; t < 40; t++) begin
        w = 1'($urandom);
        s = 2'($urandom);
        a = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(1024, 32767))
                                        : 15'($urandom_range(0, 31));
        op(k, w, s, a, 16'($urandom), rd);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/xm_wb_ram_responder.md
# xm_wb_ram_responder

Wishbone classic-cycle responder that fronts a word-organised, byte-lane-writable RAM for the XM CPU bus. It is the slave end of the bus the CPU's memory controller drives: it accepts read/write requests, inserts a programmable number of wait states, and terminates each transfer with a single-cycle `ack_o`, or `err_o` for out-of-range addresses. It is used as instruction/data memory in CPU-level simulation and synthesis.

## Interface
- `WORD`, 16, data width in bits; byte lanes = WORD/8.
- `ADR_W`, WORD-(WORD/8)+1 (=15), word-address width; matches the CPU's `adr_o`.
- `DEPTH_LOG2`, 10, log2 of RAM depth in words; must be ≤ ADR_W.
- `WAIT`, 1, wait states inserted before termination; range 0..15.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `cyc_i`  in  1  bus cycle in progress.
- `stb_i`  in  1  transfer strobe.
- `we_i`  in  1  1 = write, 0 = read.
- `sel_i`  in  WORD/8  byte-lane enables; bit n covers `dat_i[8n+7:8n]`.
- `adr_i`  in  ADR_W  word address.
- `dat_i`  in  WORD  write data.
- `ack_o`  out  1  normal termination, one-cycle pulse.
- `err_o`  out  1  error termination, one-cycle pulse.
- `dat_o`  out  WORD  read data; valid only while `ack_o`=1.

## Operation
- States: IDLE, WAIT, TERM.
- IDLE: on `cyc_i & stb_i`, latch `adr_i`, `we_i`, `sel_i`, `dat_i`; set `bad` = (`adr_i` ≥ 2^DEPTH_LOG2). Load the wait counter with WAIT. If WAIT=0, go to TERM; else go to WAIT.
- WAIT: counter decrements by 1 each cycle; go to TERM when the counter is 1 at the clock edge. If `cyc_i`=0, go to IDLE (abort): no write, no ack, no err.
- Transition into TERM, with `bad`=0:
  - Write: RAM lanes with `sel`=1 are updated from the latched data. `sel`=0 still acks and writes nothing.
  - Read: the full word is registered into `dat_o`, regardless of `sel`.
  - `ack_o`=1.
- Transition into TERM, with `bad`=1: `err_o`=1, no RAM access, `dat_o`=0.
- TERM lasts exactly one cycle, then IDLE unconditionally. A request already committed is not cancelled by `cyc_i` dropping while in TERM.
- Outside TERM: `ack_o`=0, `err_o`=0, `dat_o`=0. `ack_o` and `err_o` are never both 1.
- Inputs are sampled only in IDLE; changes to `adr_i`, `dat_i`, `sel_i`, or `we_i` during WAIT/TERM have no effect.
- Back-to-back: if `cyc_i & stb_i` are high in the first IDLE cycle after TERM, that is a new transfer.
- Reset (`rst_ni`=0 at an edge): state IDLE, counter 0, `ack_o`=0, `err_o`=0, `dat_o`=0, latched request cleared. A transfer in flight is dropped with no write. RAM contents are not reset.

## Timing
- Request sampled at edge E in IDLE ⇒ `ack_o`/`err_o` high for the single cycle after edge E+WAIT.
- Latency is WAIT+1 cycles from the request edge. WAIT=0 gives the response in the cycle after the request.
- A write is visible to a read issued in the IDLE cycle immediately after its TERM.
- Throughput: one transfer per WAIT+2 cycles when back-to-back.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, then write/read, WAIT=1: write 0xBEEF to adr 0x0005 with sel=11, then read adr 0x0005.
  - `ack_o` rises 2 cycles after each request edge; the read returns `dat_o`=0xBEEF during ack; `err_o` stays 0.
- Byte lanes: write 0x1234 with sel=11; write 0xAB00 with sel=10; write 0x00CD with sel=01; read back.
  - `dat_o`=0xABCD.
  - A further write with sel=00, data 0xFFFF, then read, still returns 0xABCD.
- Out of range, DEPTH_LOG2=10: read of adr 0x0400, then write of adr 0x7FFF.
  - Each gives an `err_o` pulse at the normal latency, no `ack_o`, `dat_o`=0.
  - A read of adr 0x03FF still returns its prior contents.
- Abort: WAIT=3; a write of 0x5555 to adr 0x0010 (previously 0x1111) drops `cyc_i` one cycle after the request.
  - No ack or err, FSM back in IDLE.
  - A subsequent read of 0x0010 returns 0x1111.
- Reset mid-transfer: assert `rst_ni`=0 during WAIT of a write.
  - All outputs are 0 on the next cycle, no write occurs, the next request completes normally.
- WAIT=0, back-to-back reads of adr 1, 2, 3 with `stb_i` held high.
  - Three `ack_o` pulses, spaced 2 cycles apart, with correct data on each.
